// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the data RAM arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } arb_state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - CPU/debug arbiter for the single-port data RAM
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_read,
  input  logic              cpu_req_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_done,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic [CNT_W-1:0]  starve_q, starve_d;

  logic cpu_any;
  assign cpu_any = cpu_req_read | cpu_req_write;

  // Next-state: grant in IDLE, sequence the access, capture read data
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    op_d        = op_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    starve_d    = starve_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!dbg_req) begin
          starve_d = '0;
        end
        if (cpu_any || dbg_req) begin
          state_d = ST_ACCESS;
          // Debug wins when the CPU is idle or has been favoured too long
          if (dbg_req && (!cpu_any || starve_q == STARVE_LIM)) begin
            owner_d     = OWNER_DBG;
            op_d        = dbg_we ? OP_WRITE : OP_READ;
            mem_addr_d  = dbg_addr;
            mem_wdata_d = dbg_wdata;
            starve_d    = '0;
          end else begin
            owner_d     = OWNER_CPU;
            // Simultaneous read and write requests resolve to a write
            op_d        = cpu_req_write ? OP_WRITE : OP_READ;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            if (dbg_req && starve_q != STARVE_LIM) begin
              starve_d = starve_q + CNT_W'(1);
            end
          end
        end
      end
      ST_ACCESS: begin
        state_d = (op_q == OP_WRITE) ? ST_DONE : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (owner_q == OWNER_CPU) begin
          cpu_rdata_d = mem_rdata;
        end else begin
          dbg_rdata_d = mem_rdata;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_CPU;
      op_q        <= OP_READ;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      op_q        <= op_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      starve_q    <= starve_d;
    end
  end

  // Strobes decode straight from the registered state so they clear with reset
  always_comb begin
    mem_en    = (state_q == ST_ACCESS);
    mem_we    = (state_q == ST_ACCESS) && (op_q == OP_WRITE);
    cpu_done  = (state_q == ST_DONE) && (owner_q == OWNER_CPU);
    dbg_ack   = (state_q == ST_DONE) && (owner_q == OWNER_DBG);
    busy      = (state_q != ST_IDLE);
    cpu_stall = cpu_any & ~cpu_done;
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req_read, cpu_req_write;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       cpu_stall, cpu_done;
  logic       dbg_req, dbg_we;
  logic [7:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic       dbg_ack;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       busy;

  logic [7:0] ram [256] = '{default: 8'h00};

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit         is_dbg;
    bit         both;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_read(cpu_req_read), .cpu_req_write(cpu_req_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .cpu_done(cpu_done),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM model
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at the negedge of an IDLE cycle; that cycle is N
  task automatic run_xact(input vec_t v, input int idx);
    int  k;
    bit  seen;
    int  lat;
    lat = v.we ? 2 : 3;
    if (v.is_dbg) begin
      dbg_req = 1'b1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
    end else begin
      cpu_req_write = v.we; cpu_req_read = ~v.we | v.both;
      cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    #1;
    if (!v.is_dbg) chk($sformatf("v%0d stall_N", idx), cpu_stall, 1);
    seen = 0;
    k = 0;
    while (!seen && k < 10) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        chk($sformatf("v%0d mem_en", idx), mem_en, 1);
        chk($sformatf("v%0d mem_we", idx), mem_we, v.we);
        chk($sformatf("v%0d mem_addr", idx), mem_addr, v.addr);
        if (v.we) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wdata);
        if (!v.is_dbg) chk($sformatf("v%0d stall_N1", idx), cpu_stall, 1);
      end
      seen = v.is_dbg ? dbg_ack : cpu_done;
    end
    chk($sformatf("v%0d latency", idx), k, lat);
    if (!v.is_dbg) begin
      chk($sformatf("v%0d stall_done", idx), cpu_stall, 0);
      if (!v.we) chk($sformatf("v%0d cpu_rdata", idx), cpu_rdata, v.exp_rdata);
    end else if (!v.we) begin
      chk($sformatf("v%0d dbg_rdata", idx), dbg_rdata, v.exp_rdata);
    end
    cpu_req_read = 1'b0; cpu_req_write = 1'b0; dbg_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k, t_cpu, t_dbg, n_cpu, cpu_before;
    bit   got_dbg, early_done;
    vec_t v;

    vecs[0] = '{0, 0, 1, 8'h10, 8'hA5, 8'h00};
    vecs[1] = '{0, 0, 0, 8'h10, 8'h00, 8'hA5};
    vecs[2] = '{1, 0, 1, 8'h30, 8'h5A, 8'h00};
    vecs[3] = '{1, 0, 0, 8'h30, 8'h00, 8'h5A};
    vecs[4] = '{0, 0, 0, 8'h30, 8'h00, 8'h5A};
    vecs[5] = '{0, 1, 1, 8'h40, 8'h77, 8'h00};
    vecs[6] = '{0, 0, 0, 8'h40, 8'h00, 8'h77};
    vecs[7] = '{0, 0, 1, 8'hFF, 8'h01, 8'h00};
    vecs[8] = '{1, 0, 0, 8'hFF, 8'h00, 8'h01};
    vecs[9] = '{1, 0, 0, 8'h10, 8'h00, 8'hA5};

    // Reset held with requests pending
    reset = 1'b0;
    cpu_req_read = 1'b0; cpu_req_write = 1'b1; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst%0d mem_en", c), mem_en, 0);
      chk($sformatf("rst%0d cpu_done", c), cpu_done, 0);
      chk($sformatf("rst%0d dbg_ack", c), dbg_ack, 0);
      chk($sformatf("rst%0d busy", c), busy, 0);
      chk($sformatf("rst%0d cpu_rdata", c), cpu_rdata, 0);
      chk($sformatf("rst%0d dbg_rdata", c), dbg_rdata, 0);
    end
    cpu_req_write = 1'b0; dbg_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst busy", busy, 0);

    // Directed transaction table
    for (int i = 0; i < 10; i++) run_xact(vecs[i], i);
    chk("cpu_rdata held", cpu_rdata, 8'h77);
    chk("dbg_rdata held", dbg_rdata, 8'hA5);

    // Simultaneous CPU read and debug write to the same address
    cpu_req_read = 1'b1; cpu_addr = 8'h20;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 8'h3C;
    t_cpu = -1; t_dbg = -1;
    for (k = 1; k <= 20 && t_dbg < 0; k++) begin
      @(negedge clk);
      if (cpu_done) begin
        t_cpu = k;
        chk("arb cpu_rdata", cpu_rdata, 8'h00);
        cpu_req_read = 1'b0;
      end
      if (dbg_ack) begin
        t_dbg = k;
        dbg_req = 1'b0;
      end
    end
    cpu_req_read = 1'b0; dbg_req = 1'b0;
    chk("arb cpu_done cycle", t_cpu, 3);
    chk("arb dbg_ack cycle", t_dbg, 6);
    @(negedge clk);
    v = '{0, 0, 0, 8'h20, 8'h00, 8'h3C};
    run_xact(v, 20);

    // Starvation limit: back-to-back CPU writes with debug held
    cpu_req_write = 1'b1; cpu_addr = 8'h60; cpu_wdata = 8'h11;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h50; dbg_wdata = 8'hEE;
    n_cpu = 0; got_dbg = 0; cpu_before = -1;
    for (int c = 0; c < 60 && !(got_dbg && n_cpu >= cpu_before + 2); c++) begin
      @(negedge clk);
      if (cpu_done) n_cpu++;
      if (dbg_ack) begin
        got_dbg = 1;
        cpu_before = n_cpu;
        dbg_req = 1'b0;
      end
    end
    cpu_req_write = 1'b0; dbg_req = 1'b0;
    repeat (6) @(negedge clk);
    chk("starve dbg granted", got_dbg, 1);
    chk("starve cpu before dbg", cpu_before, 4);
    chk("starve cpu resumed", (n_cpu >= cpu_before + 2), 1);
    v = '{1, 0, 0, 8'h50, 8'h00, 8'hEE};
    run_xact(v, 21);

    // Reset during ACCESS of a CPU read
    v = '{0, 0, 1, 8'h70, 8'h99, 8'h00};
    run_xact(v, 22);
    cpu_req_read = 1'b1; cpu_addr = 8'h70;
    @(negedge clk);
    chk("midrst in access", mem_en, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst cpu_done", cpu_done, 0);
    chk("midrst busy", busy, 0);
    chk("midrst cpu_rdata", cpu_rdata, 0);
    reset = 1'b1;
    early_done = 0;
    t_cpu = -1;
    for (k = 1; k <= 10 && t_cpu < 0; k++) begin
      @(negedge clk);
      if (cpu_done) t_cpu = k;
    end
    cpu_req_read = 1'b0;
    chk("midrst regrant latency", t_cpu, 3);
    chk("midrst cpu_rdata after", cpu_rdata, 8'h99);
    @(negedge clk);
    chk("final idle", busy, early_done);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
